// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Purpose  : Round-robin arbiter for the 16-bit 4-input datapath bus mux.
//            Drives the registered mux Select and a one-hot Grant. Adds a
//            one-cycle turnaround between owners and a maximum hold time
//            so that a single requester cannot starve the others.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
    parameter int MAX_HOLD = 8,   // 0 = unlimited hold
    parameter int HOLD_W   = 4    // 2**HOLD_W must exceed MAX_HOLD
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic [3:0] Req,
    output logic [3:0] Grant,
    output logic [1:0] Select,
    output logic       BusValid,
    output logic       Preempt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    localparam bit              C_PREEMPT_EN = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] C_HOLD_MAX = HOLD_W'(MAX_HOLD);
    // With unlimited hold the counter simply parks at all-ones.
    localparam logic [HOLD_W-1:0] C_HOLD_SAT = C_PREEMPT_EN ? C_HOLD_MAX : {HOLD_W{1'b1}};
    localparam logic [HOLD_W-1:0] C_HOLD_ONE = HOLD_W'(1);

    state_t              state_q, state_d;
    logic [3:0]          grant_q, grant_d;
    logic [1:0]          select_q, select_d;
    logic                preempt_q, preempt_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [1:0]          last_q, last_d;

    logic                win_found;
    logic [1:0]          win_idx;
    logic [1:0]          cand;
    logic [3:0]          other_req;

    // Round-robin scan: first requester found starting just after the last owner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        cand      = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!win_found && Req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Anyone other than the current owner asking for the bus.
    assign other_req = Req & ~grant_q;

    // Next-state and registered-output computation for the arbiter FSM.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        select_d  = select_q;
        preempt_d = 1'b0;
        hold_d    = hold_q;
        last_d    = last_q;

        case (state_q)
            ST_IDLE, ST_TURN: begin
                if (win_found) begin
                    grant_d  = 4'b0001 << win_idx;
                    select_d = win_idx;
                    hold_d   = C_HOLD_ONE;
                    state_d  = ST_GRANT;
                end else begin
                    grant_d  = 4'b0000;
                    state_d  = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!Req[select_q]) begin
                    // Owner let go voluntarily.
                    grant_d = 4'b0000;
                    last_d  = select_q;
                    state_d = ST_TURN;
                end else if (C_PREEMPT_EN && (hold_q == C_HOLD_MAX) && (|other_req)) begin
                    // Owner has used its full slot and someone else is waiting.
                    grant_d   = 4'b0000;
                    last_d    = select_q;
                    preempt_d = 1'b1;
                    state_d   = ST_TURN;
                end else if (hold_q != C_HOLD_SAT) begin
                    hold_d = hold_q + C_HOLD_ONE;
                end
            end
            default: begin
                grant_d = 4'b0000;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears Grant without waiting for a clock.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= 4'b0000;
            select_q  <= 2'd0;
            preempt_q <= 1'b0;
            hold_q    <= '0;
            last_q    <= 2'd3;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            select_q  <= select_d;
            preempt_q <= preempt_d;
            hold_q    <= hold_d;
            last_q    <= last_d;
        end
    end

    assign Grant    = grant_q;
    assign Select   = select_q;
    assign BusValid = |grant_q;
    assign Preempt  = preempt_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Purpose  : Self-checking bench for bus_arbiter: directed scenarios plus a
//            randomized run compared against a behavioural arbiter model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

    localparam int MH = 8;

    logic       Clock;
    logic       Reset_n;
    logic [3:0] Req;
    logic [3:0] Grant;
    logic [1:0] Select;
    logic       BusValid;
    logic       Preempt;

    int errors = 0;
    int checks = 0;

    // Behavioural model: current owner (-1 = none), last owner, hold, select, preempt.
    int m_owner;
    int m_last;
    int m_hold;
    int m_sel;
    int m_pre;

    bus_arbiter #(.MAX_HOLD(MH), .HOLD_W(4)) dut (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .Req      (Req),
        .Grant    (Grant),
        .Select   (Select),
        .BusValid (BusValid),
        .Preempt  (Preempt)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [7:0] model_vec();
        logic [3:0] g;
        g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        return {g, 2'(m_sel), (m_owner >= 0), 1'(m_pre)};
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 3;
        m_hold  = 0;
        m_sel   = 0;
        m_pre   = 0;
    endtask

    // Advance model by one edge using the Req currently applied, then clock the DUT.
    task automatic tick();
        logic [3:0] r;
        int         o;
        int         idx;
        bit         found;
        r = Req;
        if (m_owner >= 0) begin
            o = m_owner;
            if (!r[o]) begin
                m_owner = -1; m_last = o; m_pre = 0;
            end else if (MH != 0 && m_hold == MH && (r & ~(4'b0001 << o)) != 4'b0000) begin
                m_owner = -1; m_last = o; m_pre = 1;
            end else begin
                if (m_hold < MH) m_hold = m_hold + 1;
                m_pre = 0;
            end
        end else begin
            m_pre = 0;
            found = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                idx = (m_last + k) % 4;
                if (!found && r[idx]) begin
                    found = 1'b1; m_owner = idx; m_sel = idx; m_hold = 1;
                end
            end
        end
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Req = 4'b0000;
        Reset_n = 1'b0;
        model_reset();
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        Req = 4'b1111;
        model_reset();
        #13;
        checks++;
        if ({Grant, Select, BusValid, Preempt} !== 8'b0000_00_0_0) begin
            errors++;
            $display("FAIL reset_state got G=%b S=%0d V=%b P=%b want G=0000 S=0 V=0 P=0",
                     Grant, Select, BusValid, Preempt);
        end
        Reset_n = 1'b1;
        tick();
        checks++;
        if (Grant !== 4'b0001 || Select !== 2'd0 || BusValid !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant got G=%b S=%0d V=%b want G=0001 S=0 V=1",
                     Grant, Select, BusValid);
        end
    endtask

    task automatic test_single();
        do_reset();
        Req = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (Grant !== 4'b0100 || Select !== 2'd2 || BusValid !== 1'b1) begin
                errors++;
                $display("FAIL single_hold c=%0d got G=%b S=%0d V=%b want G=0100 S=2 V=1",
                         c, Grant, Select, BusValid);
            end
        end
        Req = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (Grant !== 4'b0000 || Select !== 2'd2 || BusValid !== 1'b0) begin
                errors++;
                $display("FAIL single_release c=%0d got G=%b S=%0d V=%b want G=0000 S=2 V=0",
                         c, Grant, Select, BusValid);
            end
        end
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        do_reset();
        Req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            for (int c = 0; c < 2; c++) begin
                tick();
                checks++;
                if (Grant !== (4'b0001 << order[n]) || Select !== 2'(order[n])) begin
                    errors++;
                    $display("FAIL rr_grant n=%0d c=%0d got G=%b S=%0d want owner %0d",
                             n, c, Grant, Select, order[n]);
                end
            end
            Req[order[n]] = 1'b0;
            tick();
            checks++;
            if (Grant !== 4'b0000 || BusValid !== 1'b0 || Select !== 2'(order[n])) begin
                errors++;
                $display("FAIL rr_turn n=%0d got G=%b V=%b S=%0d want G=0000 V=0 S=%0d",
                         n, Grant, BusValid, Select, order[n]);
            end
            Req[order[n]] = 1'b1;
        end
    endtask

    task automatic test_preempt();
        do_reset();
        Req = 4'b0010;
        tick();
        tick();
        Req = 4'b1010;
        for (int c = 3; c <= 8; c++) begin
            tick();
            checks++;
            if (Grant !== 4'b0010 || Preempt !== 1'b0) begin
                errors++;
                $display("FAIL preempt_hold cycle=%0d got G=%b P=%b want G=0010 P=0",
                         c, Grant, Preempt);
            end
        end
        tick();
        checks++;
        if (Grant !== 4'b0000 || Preempt !== 1'b1 || Select !== 2'd1) begin
            errors++;
            $display("FAIL preempt_release got G=%b P=%b S=%0d want G=0000 P=1 S=1",
                     Grant, Preempt, Select);
        end
        tick();
        checks++;
        if (Grant !== 4'b1000 || Select !== 2'd3 || Preempt !== 1'b0) begin
            errors++;
            $display("FAIL preempt_next got G=%b S=%0d P=%b want G=1000 S=3 P=0",
                     Grant, Select, Preempt);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        Req = 4'b0100;
        for (int c = 1; c <= 20; c++) begin
            tick();
            checks++;
            if (Grant !== 4'b0100 || Preempt !== 1'b0 ||
                dut.hold_q !== 4'((c < MH) ? c : MH)) begin
                errors++;
                $display("FAIL saturate cycle=%0d got G=%b P=%b hold=%0d want G=0100 P=0 hold=%0d",
                         c, Grant, Preempt, dut.hold_q, (c < MH) ? c : MH);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        Req = 4'b1000;
        tick();
        tick();
        checks++;
        if (Grant !== 4'b1000) begin
            errors++;
            $display("FAIL async_pre got G=%b want G=1000", Grant);
        end
        #2;
        Reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (Grant !== 4'b0000 || BusValid !== 1'b0) begin
            errors++;
            $display("FAIL async_drop got G=%b V=%b want G=0000 V=0", Grant, BusValid);
        end
        Req = 4'b1010;
        #2;
        Reset_n = 1'b1;
        tick();
        checks++;
        if (Grant !== 4'b0010 || Select !== 2'd1) begin
            errors++;
            $display("FAIL async_after got G=%b S=%0d want G=0010 S=1", Grant, Select);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0) Req = 4'($urandom_range(0, 15));
            tick();
            exp = model_vec();
            checks++;
            if ({Grant, Select, BusValid, Preempt} !== exp) begin
                errors++;
                $display("FAIL random cycle=%0d req=%b got G=%b S=%0d V=%b P=%b want G=%b S=%0d V=%b P=%b",
                         c, Req, Grant, Select, BusValid, Preempt,
                         exp[7:4], exp[3:2], exp[1], exp[0]);
            end
            checks++;
            if ($countones(Grant) > 1) begin
                errors++;
                $display("FAIL random_onehot cycle=%0d got G=%b want at most one bit", c, Grant);
            end
        end
    endtask

    initial begin
        Reset_n = 1'b0;
        Req = 4'b0000;
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_preempt();
        test_saturate();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
